fpu_config_responder: RTL

Memory-mapped configuration responder on the far side of the FPU configuration load handshake. It holds the six 32-bit FPU configuration words (3×3 filter, image dimensions, start/result addresses) written by the CPU. When the FPU loader runs, it answers the loader's address stream with data and a valid strobe. CPU writes are locked out while a load is in progress, so the FPU never sees a half-updated configuration.

---
 rtl/fpu_cfg_pkg.sv | 26 ++
 rtl/fpu_cfg_regfile.sv | 70 +++++++
 rtl/fpu_config_responder.sv | 91 +++++++++
 3 files changed

// File: rtl/fpu_cfg_pkg.sv
// fpu_cfg_pkg: register map offsets, state type and address decode for the FPU config responder.
package fpu_cfg_pkg;
  localparam logic [31:0] CFG_FILT0_OFS  = 32'h00;
  localparam logic [31:0] CFG_FILT1_OFS  = 32'h04;
  localparam logic [31:0] CFG_FILT2_OFS  = 32'h08;
  localparam logic [31:0] CFG_DIM_OFS    = 32'h0C;
  localparam logic [31:0] CFG_START_OFS  = 32'h10;
  localparam logic [31:0] CFG_RESULT_OFS = 32'h14;
  localparam int CFG_NUM_WORDS = 6;
  localparam logic [31:0] CFG_MAP_BYTES = CFG_RESULT_OFS + 32'h4;

  typedef enum logic {IDLE, SERVE} fpu_cfg_state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } cfg_dec_t;

  // The subtraction wraps addresses below base to huge offsets, so one compare bounds both sides.
  function automatic cfg_dec_t cfg_decode(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] ofs;
    ofs = addr - base;
    cfg_decode.ok  = (ofs < CFG_MAP_BYTES) && (ofs[1:0] == 2'b00);
    cfg_decode.idx = ofs[4:2];
  endfunction
endpackage

// File: rtl/fpu_cfg_regfile.sv
// fpu_cfg_regfile: six config words, written mask and combinational decode/read mux.
// FPU_CFG_READBACK_EN adds a second read port for CPU readback.
module fpu_cfg_regfile
  import fpu_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_clr,
  input  logic [31:0] i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_ok,
  output logic        o_wr_ok,
`ifdef FPU_CFG_READBACK_EN
  input  logic [31:0] i_cpu_rd_addr,
  output logic [31:0] o_cpu_rd_data,
  output logic        o_cpu_rd_ok,
`endif
  output logic        o_cfg_complete
);
  cfg_dec_t w_wr_dec, w_rd_dec;
  logic [31:0] r_word [CFG_NUM_WORDS];
  logic [CFG_NUM_WORDS-1:0] r_mask, w_mask_nxt;
  logic w_wr_fire;

  assign w_wr_dec  = cfg_decode(i_wr_addr, BASE_ADDR);
  assign w_rd_dec  = cfg_decode(i_rd_addr, BASE_ADDR);
  assign o_wr_ok   = w_wr_dec.ok;
  assign o_rd_ok   = w_rd_dec.ok;
  assign w_wr_fire = i_wr_en && w_wr_dec.ok;

  always_comb begin
    o_rd_data  = '0;
    w_mask_nxt = r_mask;
    for (int i = 0; i < CFG_NUM_WORDS; i++) begin
      o_rd_data     = (w_rd_dec.ok && w_rd_dec.idx == 3'(i)) ? r_word[i] : o_rd_data;
      w_mask_nxt[i] = w_mask_nxt[i] | (w_wr_fire && w_wr_dec.idx == 3'(i));
    end
    w_mask_nxt = i_clr ? '0 : w_mask_nxt;
  end

`ifdef FPU_CFG_READBACK_EN
  cfg_dec_t w_cpu_dec;
  assign w_cpu_dec   = cfg_decode(i_cpu_rd_addr, BASE_ADDR);
  assign o_cpu_rd_ok = w_cpu_dec.ok;
  always_comb begin
    o_cpu_rd_data = '0;
    for (int i = 0; i < CFG_NUM_WORDS; i++)
      o_cpu_rd_data = (w_cpu_dec.ok && w_cpu_dec.idx == 3'(i)) ? r_word[i] : o_cpu_rd_data;
  end
`endif

  // Only filter[8] lives in word 2; its upper bits are never stored so they read back 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CFG_NUM_WORDS; i++) r_word[i] <= '0;
      r_mask         <= '0;
      o_cfg_complete <= 1'b0;
    end else begin
      for (int i = 0; i < CFG_NUM_WORDS; i++)
        if (w_wr_fire && w_wr_dec.idx == 3'(i))
          r_word[i] <= (3'(i) == CFG_FILT2_OFS[4:2]) ? {24'h0, i_wr_data[7:0]} : i_wr_data;
      r_mask         <= w_mask_nxt;
      o_cfg_complete <= &w_mask_nxt;
    end
endmodule

// File: rtl/fpu_config_responder.sv
// fpu_config_responder: holds CPU-written FPU config words and serves them to the loader with 1-cycle latency.
// Optional CPU readback port enabled by FPU_CFG_READBACK_EN.
module fpu_config_responder
  import fpu_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_wr_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        cpu_wr_ready,
  input  logic        load_config_start,
  input  logic        load_config_done,
  input  logic [31:0] address_mem,
  output logic [31:0] data_mem,
  output logic        mapped_data_valid,
  output logic        cfg_complete,
`ifdef FPU_CFG_READBACK_EN
  input  logic        cpu_rd_en,
  input  logic [31:0] cpu_rd_addr,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_rd_valid,
`endif
  output logic        addr_err
);
  fpu_cfg_state_t r_state;
  logic [31:0] w_rd_data;
  logic w_rd_ok, w_wr_ok, w_wr_fire, w_serve, w_clr, w_cpu_rd_err;

  assign w_wr_fire = cpu_wr_en && cpu_wr_ready;
  assign w_serve   = (r_state == SERVE) && !load_config_done;
  assign w_clr     = (r_state == SERVE) && load_config_done;

`ifdef FPU_CFG_READBACK_EN
  logic [31:0] w_cpu_rd_data;
  logic w_cpu_rd_ok;
  assign w_cpu_rd_err = cpu_rd_en && !w_cpu_rd_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpu_rd_data  <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= cpu_rd_en;
      if (cpu_rd_en) cpu_rd_data <= w_cpu_rd_data;
    end
`else
  assign w_cpu_rd_err = 1'b0;
`endif

  fpu_cfg_regfile #(.BASE_ADDR(BASE_ADDR)) u_regfile (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (w_wr_fire),
    .i_wr_addr     (cpu_wr_addr),
    .i_wr_data     (cpu_wr_data),
    .i_clr         (w_clr),
    .i_rd_addr     (address_mem),
    .o_rd_data     (w_rd_data),
    .o_rd_ok       (w_rd_ok),
    .o_wr_ok       (w_wr_ok),
`ifdef FPU_CFG_READBACK_EN
    .i_cpu_rd_addr (cpu_rd_addr),
    .o_cpu_rd_data (w_cpu_rd_data),
    .o_cpu_rd_ok   (w_cpu_rd_ok),
`endif
    .o_cfg_complete(cfg_complete)
  );

  // The done cycle itself is not served, so valid falls right after done.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state           <= IDLE;
      cpu_wr_ready      <= 1'b1;
      data_mem          <= '0;
      mapped_data_valid <= 1'b0;
      addr_err          <= 1'b0;
    end else begin
      addr_err          <= (w_wr_fire && !w_wr_ok) || (w_serve && !w_rd_ok) || w_cpu_rd_err;
      mapped_data_valid <= w_serve;
      if (w_serve) data_mem <= w_rd_data;
      if (r_state == IDLE && load_config_start) begin
        r_state      <= SERVE;
        cpu_wr_ready <= 1'b0;
      end else if (w_clr) begin
        r_state      <= IDLE;
        cpu_wr_ready <= 1'b1;
      end
    end
endmodule
